vending_machine_param: RTL and testbench

Parametrised successor to the fixed 4-item vending machine. Credit accumulates over multiple coin inserts, and prices are set per item by parameter. Each item has a stock counter with a sold-out flag. Cancel and change refunds are supported, and a 4-state FSM controls the vend sequence. The block sits between the coin/keypad front-end and the dispenser/refund actuators.

---
 rtl/vending_pkg.sv | 26 ++
 rtl/vm_stock_bank.sv | 43 ++++
 rtl/vending_machine_param.sv | 201 ++++++++++++++++++++
 tb/tb_vending_machine_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the parametrised vending machine.
// The price helper slices one item's price out of a flat price vector.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vm_state_t;

    localparam int PRICE_VEC_MAX = 1024;

    localparam logic [31:0] DEFAULT_PRICES = {8'd20, 8'd17, 8'd15, 8'd10};

    function automatic logic [31:0] price_at(input logic [PRICE_VEC_MAX-1:0] prices,
                                             input int unsigned idx,
                                             input int unsigned credit_w);
        logic [PRICE_VEC_MAX-1:0] shifted;
        logic [31:0]              mask;
        shifted = prices >> (idx * credit_w);
        mask    = (credit_w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << credit_w) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters with a zero flag per item.
// A decrement is only applied to a non-empty counter, so counters never wrap.
module vm_stock_bank
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_en,
    input  logic [SEL_W-1:0]     dec_idx,
    input  logic                 restock,
    output logic [NUM_ITEMS-1:0] stock_zero
);

    logic [STOCK_W-1:0] stock_r [NUM_ITEMS];

    // Stock counters: reload on reset or restock, otherwise decrement the selected item.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (reset || restock) begin
                stock_r[i] <= STOCK_W'(INIT_STOCK);
            end else if (dec_en && (dec_idx == SEL_W'(i)) &&
                         (stock_r[i] != {STOCK_W{1'b0}})) begin
                stock_r[i] <= stock_r[i] - STOCK_W'(1'b1);
            end else begin
                stock_r[i] <= stock_r[i];
            end
        end
    end

    // Sold-out flags derived directly from the counters.
    always_comb begin
        stock_zero = {NUM_ITEMS{1'b0}};
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_zero[i] = (stock_r[i] == {STOCK_W{1'b0}});
        end
    end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending machine: credit accumulation, per-item pricing and stock,
// vend sequencing and change/cancel refunds. All outputs except sold_out are registered.
module vending_machine_param
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int COIN_W     = 4,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 4,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = (NUM_ITEMS*CREDIT_W)'(DEFAULT_PRICES),
    localparam int SEL_W = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_valid,
    input  logic [COIN_W-1:0]    coin_in,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     item_sel,
    input  logic                 cancel,
    input  logic                 restock,
    output logic                 dispense,
    output logic [SEL_W-1:0]     dispense_item,
    output logic [CREDIT_W-1:0]  balance,
    output logic [CREDIT_W-1:0]  refund,
    output logic                 refund_valid,
    output logic                 coin_reject,
    output logic                 sel_error,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 busy
);

    localparam logic [CREDIT_W-1:0] MAX_CREDIT = {CREDIT_W{1'b1}};

    logic [CREDIT_W-1:0] price_tab_s [NUM_ITEMS];

    if (NUM_ITEMS < 2) begin : g_bad_items
        $error("vending_machine_param: NUM_ITEMS must be at least 2");
    end

    if (COIN_W > CREDIT_W) begin : g_bad_coin
        $error("vending_machine_param: COIN_W must not exceed CREDIT_W");
    end

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
        localparam logic [31:0] PRICE_G = price_at(PRICE_VEC_MAX'(PRICES), g, CREDIT_W);
        assign price_tab_s[g] = CREDIT_W'(PRICE_G);
        if (PRICE_G > 32'(MAX_CREDIT)) begin : g_bad_price
            $error("vending_machine_param: price of item %0d exceeds MAX_CREDIT", g);
        end
    end

    vm_state_t            state_r, next_state_s;
    logic [CREDIT_W-1:0]  balance_r, balance_nxt_s;
    logic [CREDIT_W-1:0]  refund_r, refund_nxt_s;
    logic                 refund_valid_r, refund_valid_nxt_s;
    logic                 dispense_r, dispense_nxt_s;
    logic [SEL_W-1:0]     dispense_item_r, dispense_item_nxt_s;
    logic                 coin_reject_r, coin_reject_nxt_s;
    logic                 sel_error_r, sel_error_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 dec_en_s, restock_en_s;
    logic [NUM_ITEMS-1:0] stock_zero_s;
    logic                 coin_nz_s, sel_in_range_s, sel_ok_s;
    logic [CREDIT_W:0]    sum_s;
    logic [CREDIT_W-1:0]  price_sel_s;

    // One extra bit catches overflow past MAX_CREDIT instead of wrapping.
    assign coin_nz_s      = coin_valid && (coin_in != {COIN_W{1'b0}});
    assign sum_s          = {1'b0, balance_r} + (CREDIT_W+1)'(coin_in);
    assign sel_in_range_s = (32'(item_sel) < 32'(NUM_ITEMS));
    assign price_sel_s    = sel_in_range_s ? price_tab_s[item_sel] : MAX_CREDIT;
    assign sel_ok_s       = sel_in_range_s && !stock_zero_s[item_sel] && (balance_r >= price_sel_s);

    vm_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .SEL_W      (SEL_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk        (clk),
        .reset      (reset),
        .dec_en     (dec_en_s),
        .dec_idx    (item_sel),
        .restock    (restock_en_s),
        .stock_zero (stock_zero_s)
    );

    // Next-state and next-output decode; cancel beats selection beats coin in CREDIT.
    always_comb begin
        next_state_s        = state_r;
        balance_nxt_s       = balance_r;
        refund_nxt_s        = {CREDIT_W{1'b0}};
        refund_valid_nxt_s  = 1'b0;
        dispense_nxt_s      = 1'b0;
        dispense_item_nxt_s = {SEL_W{1'b0}};
        coin_reject_nxt_s   = 1'b0;
        sel_error_nxt_s     = 1'b0;
        dec_en_s            = 1'b0;
        restock_en_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                restock_en_s    = restock;
                sel_error_nxt_s = sel_valid;
                if (coin_nz_s) begin
                    balance_nxt_s = CREDIT_W'(coin_in);
                    next_state_s  = ST_CREDIT;
                end else begin
                    balance_nxt_s = {CREDIT_W{1'b0}};
                    next_state_s  = ST_IDLE;
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    sel_error_nxt_s    = sel_valid;
                    coin_reject_nxt_s  = coin_nz_s;
                    refund_nxt_s       = balance_r;
                    refund_valid_nxt_s = 1'b1;
                    balance_nxt_s      = {CREDIT_W{1'b0}};
                    next_state_s       = ST_CHANGE;
                end else if (sel_valid) begin
                    coin_reject_nxt_s = coin_nz_s;
                    if (sel_ok_s) begin
                        balance_nxt_s       = balance_r - price_sel_s;
                        dec_en_s            = 1'b1;
                        dispense_nxt_s      = 1'b1;
                        dispense_item_nxt_s = item_sel;
                        next_state_s        = ST_VEND;
                    end else begin
                        sel_error_nxt_s = 1'b1;
                    end
                end else if (coin_nz_s) begin
                    if (sum_s[CREDIT_W]) begin
                        coin_reject_nxt_s = 1'b1;
                    end else begin
                        balance_nxt_s = sum_s[CREDIT_W-1:0];
                    end
                end else begin
                    next_state_s = ST_CREDIT;
                end
            end
            ST_VEND: begin
                coin_reject_nxt_s = coin_nz_s;
                if (balance_r != {CREDIT_W{1'b0}}) begin
                    refund_nxt_s       = balance_r;
                    refund_valid_nxt_s = 1'b1;
                    balance_nxt_s      = {CREDIT_W{1'b0}};
                    next_state_s       = ST_CHANGE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_reject_nxt_s = coin_nz_s;
                balance_nxt_s     = {CREDIT_W{1'b0}};
                next_state_s      = ST_IDLE;
            end
            default: begin
                balance_nxt_s = {CREDIT_W{1'b0}};
                next_state_s  = ST_IDLE;
            end
        endcase
        busy_nxt_s = (next_state_s == ST_VEND) || (next_state_s == ST_CHANGE);
    end

    // State and output registers; credit held at reset is dropped without a refund.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            balance_r       <= {CREDIT_W{1'b0}};
            refund_r        <= {CREDIT_W{1'b0}};
            refund_valid_r  <= 1'b0;
            dispense_r      <= 1'b0;
            dispense_item_r <= {SEL_W{1'b0}};
            coin_reject_r   <= 1'b0;
            sel_error_r     <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            balance_r       <= balance_nxt_s;
            refund_r        <= refund_nxt_s;
            refund_valid_r  <= refund_valid_nxt_s;
            dispense_r      <= dispense_nxt_s;
            dispense_item_r <= dispense_item_nxt_s;
            coin_reject_r   <= coin_reject_nxt_s;
            sel_error_r     <= sel_error_nxt_s;
            busy_r          <= busy_nxt_s;
        end
    end

    assign dispense      = dispense_r;
    assign dispense_item = dispense_item_r;
    assign balance       = balance_r;
    assign refund        = refund_r;
    assign refund_valid  = refund_valid_r;
    assign coin_reject   = coin_reject_r;
    assign sel_error     = sel_error_r;
    assign busy          = busy_r;
    assign sold_out      = stock_zero_s;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: a credit/stock model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_vending_machine_param;

    localparam int NI   = 4;
    localparam int MAXC = 255;
    localparam int INIT = 2;
    localparam int PRICE [NI] = '{10, 15, 17, 20};

    logic       clk = 1'b0;
    logic       reset, coin_valid, sel_valid, cancel, restock;
    logic [3:0] coin_in;
    logic [1:0] item_sel;
    logic       dispense, refund_valid, coin_reject, sel_error, busy;
    logic [1:0] dispense_item;
    logic [7:0] balance, refund;
    logic [3:0] sold_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    // model: credit held, whether this cycle is the vend or refund cycle, stock per item
    int m_credit;
    bit m_vend, m_refund;
    int m_stock [NI];
    int e_refund, e_item;
    bit e_disp, e_rv, e_rej, e_serr;

    always #5 clk = ~clk;

    vending_machine_param #(
        .NUM_ITEMS  (4),
        .COIN_W     (4),
        .CREDIT_W   (8),
        .STOCK_W    (4),
        .INIT_STOCK (INIT),
        .PRICES     ({8'd20, 8'd17, 8'd15, 8'd10})
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_valid    (coin_valid),
        .coin_in       (coin_in),
        .sel_valid     (sel_valid),
        .item_sel      (item_sel),
        .cancel        (cancel),
        .restock       (restock),
        .dispense      (dispense),
        .dispense_item (dispense_item),
        .balance       (balance),
        .refund        (refund),
        .refund_valid  (refund_valid),
        .coin_reject   (coin_reject),
        .sel_error     (sel_error),
        .sold_out      (sold_out),
        .busy          (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d at %0t", name, act, exp, $time);
    endtask

    task automatic give_refund();
        e_rv     = 1'b1;
        e_refund = m_credit;
        m_credit = 0;
        m_refund = 1'b1;
    endtask

    task automatic model_step();
        bit coin_ok;
        coin_ok  = coin_valid && (coin_in != 4'd0);
        e_disp   = 1'b0; e_item = 0; e_rv = 1'b0; e_refund = 0;
        e_rej    = 1'b0; e_serr = 1'b0;
        if (reset) begin
            m_credit = 0; m_vend = 1'b0; m_refund = 1'b0;
            for (int i = 0; i < NI; i++) m_stock[i] = INIT;
        end else if (m_vend) begin
            m_vend = 1'b0;
            e_rej  = coin_ok;
            if (m_credit > 0) give_refund();
        end else if (m_refund) begin
            m_refund = 1'b0;
            e_rej    = coin_ok;
        end else if (m_credit == 0) begin
            if (restock) for (int i = 0; i < NI; i++) m_stock[i] = INIT;
            e_serr = sel_valid;
            if (coin_ok) m_credit = int'(coin_in);
        end else if (cancel) begin
            e_serr = sel_valid;
            e_rej  = coin_ok;
            give_refund();
        end else if (sel_valid) begin
            e_rej = coin_ok;
            if (m_stock[item_sel] > 0 && m_credit >= PRICE[item_sel]) begin
                m_credit -= PRICE[item_sel];
                m_stock[item_sel]--;
                e_disp = 1'b1;
                e_item = int'(item_sel);
                m_vend = 1'b1;
            end else begin
                e_serr = 1'b1;
            end
        end else if (coin_ok) begin
            if (m_credit + int'(coin_in) > MAXC) e_rej = 1'b1;
            else m_credit += int'(coin_in);
        end
    endtask

    task automatic compare();
        int e_so;
        e_so = 0;
        for (int i = 0; i < NI; i++) if (m_stock[i] == 0) e_so |= (1 << i);
        chk("dispense", int'(dispense), int'(e_disp));
        chk("dispense_item", int'(dispense_item), e_item);
        chk("balance", int'(balance), m_credit);
        chk("refund", int'(refund), e_refund);
        chk("refund_valid", int'(refund_valid), int'(e_rv));
        chk("coin_reject", int'(coin_reject), int'(e_rej));
        chk("sel_error", int'(sel_error), int'(e_serr));
        chk("sold_out", int'(sold_out), e_so);
        chk("busy", int'(busy), int'(m_vend || m_refund));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) compare();
    end

    task automatic tick(input bit cv, input int cin, input bit sv, input int sel,
                        input bit can, input bit rs, input bit rst);
        coin_valid = cv; coin_in = 4'(cin); sel_valid = sv; item_sel = 2'(sel);
        cancel = can; restock = rs; reset = rst;
        @(negedge clk);
        coin_valid = 1'b0; coin_in = 4'd0; sel_valid = 1'b0; item_sel = 2'd0;
        cancel = 1'b0; restock = 1'b0; reset = 1'b0;
    endtask

    task automatic coin(input int v);   tick(1'b1, v, 1'b0, 0, 1'b0, 1'b0, 1'b0); endtask
    task automatic sel(input int i);    tick(1'b0, 0, 1'b1, i, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_cancel();         tick(1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0); endtask
    task automatic do_reset();          tick(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1); endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin_in = 4'd0; sel_valid = 1'b0;
        item_sel = 2'd0; cancel = 1'b0; restock = 1'b0;
        do_reset(); do_reset();
        started = 1'b1;
        chk("rst_balance", int'(balance), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sold_out", int'(sold_out), 0);

        // simple purchase with exact credit
        coin(10); chk("t1_balance", int'(balance), 10);
        sel(0);
        chk("t1_dispense", int'(dispense), 1);
        chk("t1_item", int'(dispense_item), 0);
        chk("t1_balance_after", int'(balance), 0);
        idle(1);
        chk("t1_no_refund", int'(refund_valid), 0);
        chk("t1_idle", int'(busy), 0);

        // purchase with change
        coin(15); coin(5); chk("t2_balance", int'(balance), 20);
        sel(2);
        chk("t2_dispense", int'(dispense), 1);
        chk("t2_item", int'(dispense_item), 2);
        idle(1);
        chk("t2_refund_valid", int'(refund_valid), 1);
        chk("t2_refund", int'(refund), 3);
        chk("t2_model_refund", e_refund, 3);
        chk("t2_balance_zero", int'(balance), 0);
        idle(1);

        // insufficient credit, then cancel
        coin(5); sel(3);
        chk("t3_sel_error", int'(sel_error), 1);
        chk("t3_balance", int'(balance), 5);
        do_cancel();
        chk("t3_refund_valid", int'(refund_valid), 1);
        chk("t3_refund", int'(refund), 5);
        idle(1);
        sel(1);
        chk("idle_sel_error", int'(sel_error), 1);

        // saturation at MAX_CREDIT and cancel beating a coin
        repeat (17) coin(15);
        chk("t4_balance", int'(balance), 255);
        chk("t4_model_credit", m_credit, 255);
        coin(15);
        chk("t4_reject", int'(coin_reject), 1);
        chk("t4_balance_held", int'(balance), 255);
        tick(1'b1, 15, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("t4_cancel_reject", int'(coin_reject), 1);
        chk("t4_cancel_rv", int'(refund_valid), 1);
        chk("t4_cancel_refund", int'(refund), 255);
        idle(1);

        // sell out item 0, refused selection, restock
        do_reset();
        coin(10); sel(0); idle(1);
        coin(10); sel(0);
        chk("t5_sold_out", int'(sold_out), 1);
        idle(1);
        coin(10); sel(0);
        chk("t5_sel_error", int'(sel_error), 1);
        chk("t5_balance", int'(balance), 10);
        do_cancel();
        chk("t5_refund", int'(refund), 10);
        idle(1);
        tick(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("t5_restocked", int'(sold_out), 0);

        // reset mid-credit restores stock and drops credit
        coin(10); sel(0); idle(1); coin(10); sel(0); idle(1);
        chk("t6_drained", int'(sold_out), 1);
        coin(12); chk("t6_balance", int'(balance), 12);
        do_reset();
        chk("t6_rst_balance", int'(balance), 0);
        chk("t6_rst_rv", int'(refund_valid), 0);
        chk("t6_rst_stock", int'(sold_out), 0);
        coin(15); sel(0);
        tick(1'b1, 7, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("t6_vend_reject", int'(coin_reject), 1);
        chk("t6_vend_refund", int'(refund), 5);
        idle(1);

        // zero-value coin is ignored without reject
        coin(3);
        coin(0);
        chk("zero_coin_reject", int'(coin_reject), 0);
        chk("zero_coin_balance", int'(balance), 3);
        do_cancel(); idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
